board_controller: RTL
=====================

# board_controller

Board-state controller for the tic-tac-toe game. It is the writer side of the per-line win check: it accepts player moves over a valid/ready handshake, validates them, and stores them in a registered 9-cell board. It alternates turns, evaluates all eight lines after each move, and reports win, draw and game-over status to the display and top-level logic. Cell and winner encoding is shared with the line checker: 2'b00 empty, 2'b01 player X, 2'b10 player O, 2'b11 never written.

## Interface
- No parameters; board size fixed at 3x3.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- new_game  in  1  synchronous clear to a fresh game; level-sampled each edge.
- move_valid  in  1  player presents a move this cycle.
- move_pos  in  4  cell index 0-8, row-major (0 = top-left, 8 = bottom-right).
- move_ready  out  1  controller can accept a move this cycle.
- move_ack  out  1  one-cycle pulse: previous accepted move was legal and written.
- move_err  out  1  one-cycle pulse: previous accepted move was illegal and discarded.
- board  out  18  cell i at bits [2i+1:2i].
- turn  out  2  player to move: 2'b01 X, 2'b10 O.
- move_count  out  4  legal moves written this game, 0-9.
- game_over  out  1  game finished (win or draw).
- winner  out  2  winning player code; 2'b00 if no winner.
- draw  out  1  board full with no winning line.

## Operation
- State machine has three states.
  - PLAY: move_ready=1.
  - CHECK: move_ready=0.
  - OVER: move_ready=0.
- A handshake occurs when move_valid && move_ready. move_valid with move_ready=0 is ignored: no ack, no err, no state change.
- In PLAY, on a handshake:
  - If move_pos > 8 or board[move_pos] != 2'b00: move_err=1 next cycle. Board, turn and move_count unchanged; stay in PLAY.
  - Otherwise: board[move_pos] <= turn, move_count += 1, move_ack=1 next cycle, go to CHECK.
- In CHECK, evaluate the 8 lines (3 rows, 3 columns, 2 diagonals) on the registered board. A line wins when all three cells are equal and non-empty.
  - Any line wins: go to OVER, game_over=1, winner=that line's cell code.
  - Else if move_count==9: go to OVER, game_over=1, draw=1, winner=2'b00.
  - Else: toggle turn (01<->10), return to PLAY.
- Only the player who just moved can complete a line, so multiple winning lines always carry the same code. The first row/column/diagonal match may be used.
- OVER holds the board and status until new_game or reset.
- new_game, in any state and with priority over a simultaneous handshake, clears on the next edge:
  - board to all zeros;
  - turn=2'b01;
  - move_count=0;
  - game_over=0, winner=2'b00, draw=0;
  - move_ack=0, move_err=0;
  - state to PLAY.

## Timing
- Reset values, applied asynchronously: board=0, turn=2'b01, move_count=0, move_ready=1 (PLAY), move_ack=0, move_err=0, game_over=0, winner=2'b00, draw=0.
- Reset mid-game (any state) returns immediately to these values. A move in flight is lost.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- Legal move accepted at edge N:
  - board, move_count and move_ack update after edge N; move_ready=0 during cycle N..N+1.
  - After edge N+1: turn toggles and move_ready=1, or game_over/winner/draw assert.
- Illegal move accepted at edge N: move_err high for exactly cycle N..N+1; move_ready stays 1.
- Throughput is at most one legal move per 2 cycles. A back-to-back illegal retry is accepted on the very next edge.
- move_ack and move_err are never high together, and each lasts exactly one cycle.
- new_game asserted at edge N: fresh state visible after edge N; a move may be accepted at edge N+1.

## Test plan
- Reset, then X moves 0, 4, 8 and O moves 1, 2 alternately -> ack for each; after the 5th move's CHECK, game_over=1, winner=2'b01, draw=0, move_count=5, move_ready=0.
- X at 4, then O at 4 -> second move gives move_err pulse; board[9:8] stays 2'b01, turn stays 2'b10, move_count=1. Then O at 0 -> ack, board[1:0]=2'b10.
- move_pos=9, then move_pos=15 -> move_err each time; board=0, move_count=0, turn=2'b01.
- Sequence X0 O1 X2 O4 X3 O5 X7 O6 X8 -> after the 9th CHECK: game_over=1, draw=1, winner=2'b00, move_count=9.
- In OVER, hold move_valid with move_pos=3 -> no ack or err, board unchanged. Pulse new_game together with move_valid -> board=0, turn=2'b01, move_ready=1, no ack.
- Drop rst_n low in the CHECK cycle after a move -> all outputs return to reset values immediately. After release, the first move is accepted as X.

Source files
------------

// File: rtl/board_controller.sv
// board_controller: tic-tac-toe board state, move validation, turn and win/draw tracking.
module board_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        new_game,
    input  logic        move_valid,
    input  logic [3:0]  move_pos,
    output logic        move_ready,
    output logic        move_ack,
    output logic        move_err,
    output logic [17:0] board,
    output logic [1:0]  turn,
    output logic [3:0]  move_count,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic        draw
);

    localparam int unsigned NUM_CELLS = 9;
    localparam logic [1:0]  CELL_EMPTY = 2'b00;
    localparam logic [1:0]  PLAYER_X   = 2'b01;
    localparam logic [1:0]  PLAYER_O   = 2'b10;

    typedef enum logic [1:0] {
        S_PLAY  = 2'd0,
        S_CHECK = 2'd1,
        S_OVER  = 2'd2
    } state_t;

    state_t      r_state;
    logic [17:0] r_board;
    logic [1:0]  r_turn;
    logic [3:0]  r_move_count;
    logic        r_move_ready;
    logic        r_move_ack;
    logic        r_move_err;
    logic        r_game_over;
    logic [1:0]  r_winner;
    logic        r_draw;

    logic [1:0]  w_cells [NUM_CELLS];
    logic        w_illegal;
    logic [1:0]  w_win_code;

    // Returns the line's cell code when all three cells match and are occupied.
    function automatic logic [1:0] line_win(input logic [1:0] a, input logic [1:0] b,
                                            input logic [1:0] c);
        return ((a != CELL_EMPTY) && (a == b) && (b == c)) ? a : CELL_EMPTY;
    endfunction

    // Unpack the board into cells and decide whether the presented move is illegal.
    always_comb begin
        for (int i = 0; i < int'(NUM_CELLS); i++) begin
            w_cells[i] = r_board[2*i +: 2];
        end
        w_illegal = 1'b1;
        if (move_pos <= 4'd8) begin
            w_illegal = (w_cells[move_pos] != CELL_EMPTY);
        end
    end

    // Scan all eight lines; only the last mover can win, so OR-merging is safe.
    always_comb begin
        w_win_code = line_win(w_cells[0], w_cells[1], w_cells[2])
                   | line_win(w_cells[3], w_cells[4], w_cells[5])
                   | line_win(w_cells[6], w_cells[7], w_cells[8])
                   | line_win(w_cells[0], w_cells[3], w_cells[6])
                   | line_win(w_cells[1], w_cells[4], w_cells[7])
                   | line_win(w_cells[2], w_cells[5], w_cells[8])
                   | line_win(w_cells[0], w_cells[4], w_cells[8])
                   | line_win(w_cells[2], w_cells[4], w_cells[6]);
    end

    // Game FSM with registered status outputs; new_game outranks any handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_PLAY;
            r_board      <= '0;
            r_turn       <= PLAYER_X;
            r_move_count <= '0;
            r_move_ready <= 1'b1;
            r_move_ack   <= 1'b0;
            r_move_err   <= 1'b0;
            r_game_over  <= 1'b0;
            r_winner     <= CELL_EMPTY;
            r_draw       <= 1'b0;
        end else begin
            r_move_ack <= 1'b0;
            r_move_err <= 1'b0;
            if (new_game) begin
                r_state      <= S_PLAY;
                r_board      <= '0;
                r_turn       <= PLAYER_X;
                r_move_count <= '0;
                r_move_ready <= 1'b1;
                r_game_over  <= 1'b0;
                r_winner     <= CELL_EMPTY;
                r_draw       <= 1'b0;
            end else begin
                case (r_state)
                    S_PLAY: begin
                        if (move_valid) begin
                            if (w_illegal) begin
                                r_move_err <= 1'b1;
                            end else begin
                                for (int i = 0; i < int'(NUM_CELLS); i++) begin
                                    if (move_pos == 4'(i)) begin
                                        r_board[2*i +: 2] <= r_turn;
                                    end
                                end
                                r_move_count <= r_move_count + 4'd1;
                                r_move_ack   <= 1'b1;
                                r_move_ready <= 1'b0;
                                r_state      <= S_CHECK;
                            end
                        end
                    end
                    S_CHECK: begin
                        if (w_win_code != CELL_EMPTY) begin
                            r_state     <= S_OVER;
                            r_game_over <= 1'b1;
                            r_winner    <= w_win_code;
                        end else if (r_move_count == 4'd9) begin
                            r_state     <= S_OVER;
                            r_game_over <= 1'b1;
                            r_draw      <= 1'b1;
                            r_winner    <= CELL_EMPTY;
                        end else begin
                            r_turn       <= (r_turn == PLAYER_X) ? PLAYER_O : PLAYER_X;
                            r_move_ready <= 1'b1;
                            r_state      <= S_PLAY;
                        end
                    end
                    S_OVER: begin
                        r_move_ready <= 1'b0;
                    end
                    default: begin
                        r_state      <= S_PLAY;
                        r_move_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign move_ready = r_move_ready;
    assign move_ack   = r_move_ack;
    assign move_err   = r_move_err;
    assign board      = r_board;
    assign turn       = r_turn;
    assign move_count = r_move_count;
    assign game_over  = r_game_over;
    assign winner     = r_winner;
    assign draw       = r_draw;

endmodule
